softmax_sched: RTL and testbench

- Sequences the row-wise softmax datapath for one attention layer.
- Per head: streams a 32x32 int8 score matrix (128 × 64-bit bars, 4 bars per row) from the score buffer into the softmax unit as one gap-free burst.
- Collects the 128 probability bars and writes them to the probability buffer.
- Loops over the configured number of heads, then signals done to the top-level MHSA controller.

---
 rtl/softmax_sched_if.sv | 34 +++
 rtl/softmax_sched.sv | 124 ++++++++++++
 tb/tb_softmax_sched.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/softmax_sched_if.sv
// Control, score-buffer read, softmax and probability-buffer write signals of softmax_sched.
// master = the scheduler, slave = the surrounding controller, buffers and softmax unit.
interface softmax_sched_if #(
  parameter int ADDR_W = 12,
  parameter int HEAD_W = 4
) ();
  logic              start;
  logic [HEAD_W-1:0] num_heads;
  logic [ADDR_W-1:0] src_base;
  logic [ADDR_W-1:0] dst_base;
  logic              busy;
  logic              done;
  logic              err;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [63:0]       rd_data;
  logic [63:0]       sm_bar;
  logic              sm_valid;
  logic [63:0]       sm_out;
  logic              sm_out_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [63:0]       wr_data;

  modport master (
    input  start, num_heads, src_base, dst_base, rd_data, sm_out, sm_out_valid,
    output busy, done, err, rd_en, rd_addr, sm_bar, sm_valid, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, num_heads, src_base, dst_base, rd_data, sm_out, sm_out_valid,
    input  busy, done, err, rd_en, rd_addr, sm_bar, sm_valid, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/softmax_sched.sv
// Per head: one gap-free burst of N score bars into softmax, probabilities written back at zero latency.
// No backpressure on either side; an idle DRAIN longer than 2*N cycles is forced to finish with err set.
module softmax_sched #(
  parameter int ROWS   = 32,
  parameter int BEATS  = 4,
  parameter int ADDR_W = 12,
  parameter int HEAD_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  softmax_sched_if.master bus
);
  localparam int N     = ROWS * BEATS;
  localparam int CNT_W = $clog2(N) + 1;
  localparam int TO_W  = $clog2(2 * N) + 1;
  localparam logic [CNT_W-1:0]  N_C     = CNT_W'(N);
  localparam logic [CNT_W-1:0]  LAST_C  = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0]  ONE_C   = CNT_W'(1);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(2 * N - 1);
  localparam logic [TO_W-1:0]   ONE_T   = TO_W'(1);
  localparam logic [HEAD_W:0]   ONE_HX  = (HEAD_W + 1)'(1);
  localparam logic [HEAD_W-1:0] ONE_H   = HEAD_W'(1);
  localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(N);

  typedef enum logic [2:0] {IDLE, FEED, DRAIN, GAP, FIN} state_t;
  state_t state_q, state_d;

  logic [HEAD_W-1:0] nh_q, head_q;
  logic [ADDR_W-1:0] src_q, dst_q, head_off;
  logic [CNT_W-1:0]  rd_cnt, wr_cnt;
  logic [TO_W-1:0]   drain_cnt;
  logic              sm_valid_q, err_q;
  logic              start_acc, timeout, rd_en, wr_act, wr_en, last_wr, more_heads, err_evt;

  assign head_off   = ADDR_W'(head_q) * STRIDE;
  assign rd_en      = (state_q == FEED);
  assign wr_act     = (state_q != IDLE) && (state_q != FIN);
  assign wr_en      = bus.sm_out_valid && wr_act && (wr_cnt != N_C);
  // The Nth write landing this cycle already completes the head.
  assign last_wr    = (wr_cnt == N_C) || (wr_en && (wr_cnt == LAST_C));
  assign more_heads = ({1'b0, head_q} + ONE_HX) < {1'b0, nh_q};
  assign err_evt    = (bus.sm_out_valid && ((state_q == IDLE) || (wr_cnt == N_C))) || timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          start_acc = 1'b1;
          state_d   = (bus.num_heads == '0) ? FIN : FEED;
        end
      end
      FEED: begin
        if (rd_cnt == LAST_C) state_d = DRAIN;
      end
      DRAIN: begin
        if (last_wr) begin
          state_d = more_heads ? GAP : FIN;
        end else if (drain_cnt == TO_LAST) begin
          timeout = 1'b1;
          state_d = FIN;
        end
      end
      GAP:     state_d = FEED;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nh_q       <= '0;
      head_q     <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      drain_cnt  <= '0;
      sm_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sm_valid_q <= rd_en;
      if (start_acc) begin
        nh_q      <= bus.num_heads;
        src_q     <= bus.src_base;
        dst_q     <= bus.dst_base;
        head_q    <= '0;
        rd_cnt    <= '0;
        wr_cnt    <= '0;
        drain_cnt <= '0;
        err_q     <= 1'b0;
      end else begin
        if (err_evt)          err_q     <= 1'b1;
        if (rd_en)            rd_cnt    <= rd_cnt + ONE_C;
        if (wr_en)            wr_cnt    <= wr_cnt + ONE_C;
        if (state_q == DRAIN) drain_cnt <= drain_cnt + ONE_T;
        if (state_q == GAP) begin
          head_q    <= head_q + ONE_H;
          rd_cnt    <= '0;
          wr_cnt    <= '0;
          drain_cnt <= '0;
        end
      end
    end
  end

  assign bus.busy     = (state_q == FEED) || (state_q == DRAIN) || (state_q == GAP);
  assign bus.done     = (state_q == FIN);
  assign bus.err      = err_q;
  assign bus.rd_en    = rd_en;
  assign bus.rd_addr  = rd_en ? (src_q + head_off + ADDR_W'(rd_cnt)) : '0;
  assign bus.sm_valid = sm_valid_q;
  assign bus.sm_bar   = sm_valid_q ? bus.rd_data : '0;
  assign bus.wr_en    = wr_en;
  assign bus.wr_addr  = wr_en ? (dst_q + head_off + ADDR_W'(wr_cnt)) : '0;
  assign bus.wr_data  = wr_en ? bus.sm_out : '0;
endmodule

// File: tb/tb_softmax_sched.sv
// Directed bench for softmax_sched: address-tagged score memory, fixed-latency softmax model,
// negedge monitor collecting burst/write statistics, immediate assertions per directed step.
`timescale 1ns/1ps
module tb_softmax_sched;
  localparam int D = 6;
  localparam logic [63:0] MASK = 64'hFFFF_0000_FFFF_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  softmax_sched_if #(.ADDR_W(12), .HEAD_W(4)) bus ();
  softmax_sched #(.ROWS(32), .BEATS(4), .ADDR_W(12), .HEAD_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [63:0] mtag(input logic [11:0] a);
    return {4'h0, a, 4'h0, a, 4'h0, a, 4'h0, a};
  endfunction

  // Score memory and softmax model
  logic [D-1:0] pv;
  logic [63:0]  pd [D];
  logic         withhold, extra_en, extra_fire;
  int           out_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_data <= '0;
      pv          <= '0;
      extra_fire  <= 1'b0;
      out_cnt     <= 0;
      for (int i = 0; i < D; i++) pd[i] <= '0;
    end else begin
      bus.rd_data <= bus.rd_en ? mtag(bus.rd_addr) : 64'hDEAD_BEEF_DEAD_BEEF;
      pv          <= {pv[D-2:0], bus.sm_valid};
      pd[0]       <= bus.sm_bar;
      for (int i = 1; i < D; i++) pd[i] <= pd[i-1];
      extra_fire  <= extra_en && bus.sm_out_valid && (out_cnt == 127);
      if (!extra_en)             out_cnt <= 0;
      else if (bus.sm_out_valid) out_cnt <= out_cnt + 1;
    end
  end

  assign bus.sm_out_valid = (pv[D-1] & ~withhold) | extra_fire;
  assign bus.sm_out       = pd[D-1] ^ MASK;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  int          n_rd, rd_bad, rd_runs, n_sm, sm_bad, n_wr, wr_bad, n_busy;
  int          done_cnt, done_cyc, done_bad, gap_run, gmin, gmax;
  logic [11:0] rd_exp, wr_exp, src_exp, mon_s, mon_d, prev_addr;
  logic        prev_rd, prev_busy, done_prev_busy, err_at_done, clr_req;

  always @(negedge clk) begin
    if (clr_req) begin
      n_rd = 0; rd_bad = 0; rd_runs = 0; n_sm = 0; sm_bad = 0; n_wr = 0; wr_bad = 0;
      n_busy = 0; done_cnt = 0; done_cyc = 0; done_bad = 0; gap_run = 0;
      gmin = 9999; gmax = 0; rd_exp = mon_s; src_exp = mon_s; wr_exp = mon_d;
      done_prev_busy = 1'b0; err_at_done = 1'b0;
      prev_rd = bus.rd_en; prev_addr = bus.rd_addr; prev_busy = bus.busy;
    end else if (!rst_n) begin
      prev_rd = 1'b0; prev_addr = '0; prev_busy = 1'b0;
    end else begin
      if (bus.busy) n_busy++;
      if (bus.rd_en) begin
        if (bus.rd_addr !== rd_exp) rd_bad++;
        rd_exp++;
        n_rd++;
        if (!prev_rd) begin
          rd_runs++;
          if (n_rd > 1) begin
            if (gap_run < gmin) gmin = gap_run;
            if (gap_run > gmax) gmax = gap_run;
          end
          gap_run = 0;
        end
      end else if (n_rd > 0) begin
        gap_run++;
      end
      if (bus.sm_valid !== prev_rd) sm_bad++;
      if (bus.sm_valid) begin
        n_sm++;
        if (bus.sm_bar !== mtag(prev_addr)) sm_bad++;
      end else if (bus.sm_bar !== 64'h0) begin
        sm_bad++;
      end
      if (bus.wr_en) begin
        n_wr++;
        if (bus.wr_addr !== wr_exp || bus.wr_data !== (mtag(src_exp) ^ MASK)) wr_bad++;
        wr_exp++;
        src_exp++;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        if (bus.busy !== 1'b0) done_bad++;
        done_prev_busy = prev_busy;
        err_at_done = bus.err;
      end
      prev_rd = bus.rd_en; prev_addr = bus.rd_addr; prev_busy = bus.busy;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic clr(input logic [11:0] s, input logic [11:0] d);
    mon_s = s;
    mon_d = d;
    clr_req = 1'b1;
    @(negedge clk);
    #1;
    clr_req = 1'b0;
  endtask

  task automatic go(input logic [3:0] nh, input logic [11:0] s, input logic [11:0] d,
                    output int sc);
    @(posedge clk);
    #1;
    bus.start = 1'b1; bus.num_heads = nh; bus.src_base = s; bus.dst_base = d;
    sc = cyc;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int k;
    k = 0;
    while (done_cnt == 0 && k < maxc) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("done_seen", 64'(done_cnt != 0), 64'd1);
    repeat (10) @(negedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_busy"},     64'(bus.busy),     64'd0);
    check({pfx, "_done"},     64'(bus.done),     64'd0);
    check({pfx, "_rd_en"},    64'(bus.rd_en),    64'd0);
    check({pfx, "_rd_addr"},  64'(bus.rd_addr),  64'd0);
    check({pfx, "_sm_valid"}, 64'(bus.sm_valid), 64'd0);
    check({pfx, "_sm_bar"},   bus.sm_bar,        64'd0);
    check({pfx, "_wr_en"},    64'(bus.wr_en),    64'd0);
    check({pfx, "_wr_addr"},  64'(bus.wr_addr),  64'd0);
    check({pfx, "_wr_data"},  bus.wr_data,       64'd0);
  endtask

  initial begin
    int sc;
    bus.start = 1'b0; bus.num_heads = '0; bus.src_base = '0; bus.dst_base = '0;
    withhold = 1'b0; extra_en = 1'b0; clr_req = 1'b0;
    mon_s = '0; mon_d = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("rst");
    check("rst_err", 64'(bus.err), 64'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Single head
    clr(12'h100, 12'h400);
    go(4'd1, 12'h100, 12'h400, sc);
    @(negedge clk);
    check("h1_busy_next", 64'(bus.busy), 64'd1);
    check("h1_first_rd", 64'(bus.rd_addr), 64'h100);
    wait_done(400);
    check("h1_n_rd",     64'(n_rd),     64'd128);
    check("h1_rd_runs",  64'(rd_runs),  64'd1);
    check("h1_rd_bad",   64'(rd_bad),   64'd0);
    check("h1_n_sm",     64'(n_sm),     64'd128);
    check("h1_sm_bad",   64'(sm_bad),   64'd0);
    check("h1_n_wr",     64'(n_wr),     64'd128);
    check("h1_wr_bad",   64'(wr_bad),   64'd0);
    check("h1_done_cnt", 64'(done_cnt), 64'd1);
    check("h1_latency",  64'(done_cyc - sc), 64'd136);
    check("h1_busy_at_done", 64'(done_bad), 64'd0);
    check("h1_busy_before_done", 64'(done_prev_busy), 64'd1);
    check("h1_err", 64'(bus.err), 64'd0);

    // Three heads
    clr(12'h000, 12'h800);
    go(4'd3, 12'h000, 12'h800, sc);
    wait_done(1200);
    check("h3_n_rd",     64'(n_rd),     64'd384);
    check("h3_rd_runs",  64'(rd_runs),  64'd3);
    check("h3_rd_bad",   64'(rd_bad),   64'd0);
    check("h3_gap_min",  64'(gmin),     64'd8);
    check("h3_gap_max",  64'(gmax),     64'd8);
    check("h3_sm_bad",   64'(sm_bad),   64'd0);
    check("h3_n_wr",     64'(n_wr),     64'd384);
    check("h3_wr_bad",   64'(wr_bad),   64'd0);
    check("h3_done_cnt", 64'(done_cnt), 64'd1);
    check("h3_latency",  64'(done_cyc - sc), 64'd408);
    check("h3_err", 64'(bus.err), 64'd0);

    // Zero heads
    clr(12'h000, 12'h000);
    go(4'd0, 12'h123, 12'h456, sc);
    wait_done(20);
    check("h0_latency",  64'(done_cyc - sc), 64'd1);
    check("h0_n_busy",   64'(n_busy),   64'd0);
    check("h0_n_rd",     64'(n_rd),     64'd0);
    check("h0_n_wr",     64'(n_wr),     64'd0);
    check("h0_done_cnt", 64'(done_cnt), 64'd1);

    // Start while busy is ignored
    clr(12'h200, 12'h300);
    go(4'd1, 12'h200, 12'h300, sc);
    repeat (20) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.num_heads = 4'd5; bus.src_base = 12'hABC; bus.dst_base = 12'h111;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(400);
    check("re_n_rd",     64'(n_rd),     64'd128);
    check("re_rd_bad",   64'(rd_bad),   64'd0);
    check("re_n_wr",     64'(n_wr),     64'd128);
    check("re_wr_bad",   64'(wr_bad),   64'd0);
    check("re_done_cnt", 64'(done_cnt), 64'd1);
    check("re_latency",  64'(done_cyc - sc), 64'd136);

    // Extra 129th output beat
    extra_en = 1'b1;
    clr(12'h040, 12'h200);
    go(4'd1, 12'h040, 12'h200, sc);
    wait_done(400);
    check("ex_n_wr",     64'(n_wr),     64'd128);
    check("ex_wr_bad",   64'(wr_bad),   64'd0);
    check("ex_done_cnt", 64'(done_cnt), 64'd1);
    check("ex_err",      64'(bus.err),  64'd1);
    repeat (30) @(negedge clk);
    check("ex_err_sticky", 64'(bus.err), 64'd1);
    extra_en = 1'b0;

    // Softmax withholds outputs: DRAIN timeout
    withhold = 1'b1;
    clr(12'h000, 12'h000);
    go(4'd1, 12'h000, 12'h000, sc);
    @(negedge clk);
    check("to_err_cleared", 64'(bus.err), 64'd0);
    wait_done(600);
    check("to_latency",   64'(done_cyc - sc), 64'd385);
    check("to_err_done",  64'(err_at_done), 64'd1);
    check("to_n_rd",      64'(n_rd),     64'd128);
    check("to_n_wr",      64'(n_wr),     64'd0);
    check("to_done_cnt",  64'(done_cnt), 64'd1);
    withhold = 1'b0;

    // Asynchronous reset in the middle of head 1
    clr(12'h000, 12'h600);
    go(4'd2, 12'h000, 12'h600, sc);
    begin
      int k;
      k = 0;
      while (!(bus.rd_en && bus.rd_addr == 12'h0B2) && k < 400) begin
        @(negedge clk);
        #1;
        k++;
      end
      check("ar_reached_rd50", 64'(bus.rd_addr), 64'h0B2);
    end
    rst_n = 1'b0;
    #1;
    check_idle_outputs("ar");
    check("ar_err", 64'(bus.err), 64'd0);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    check("ar_no_done", 64'(done_cnt), 64'd0);
    clr(12'h000, 12'h600);
    go(4'd2, 12'h000, 12'h600, sc);
    wait_done(900);
    check("ar2_n_rd",     64'(n_rd),     64'd256);
    check("ar2_rd_bad",   64'(rd_bad),   64'd0);
    check("ar2_n_wr",     64'(n_wr),     64'd256);
    check("ar2_wr_bad",   64'(wr_bad),   64'd0);
    check("ar2_done_cnt", 64'(done_cnt), 64'd1);
    check("ar2_latency",  64'(done_cyc - sc), 64'd272);
    check("ar2_err",      64'(err_at_done), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
